// File: rtl/read_vec_arb.sv
// Burst-oriented round-robin arbiter sharing the vector read path between requesters A and B.
// Optional grant statistics are enabled by defining READ_VEC_ARB_STATS_EN.
module read_vec_arb #(
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             last_a,
  input  logic             req_b,
  input  logic             last_b,
  output logic             grant_a,
  output logic             grant_b,
  output logic             sel,
  output logic             busy,
  output logic [CNT_W-1:0] beat_cnt
`ifdef READ_VEC_ARB_STATS_EN
  ,
  output logic [15:0]      grants_a,
  output logic [15:0]      grants_b
`endif
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;    // 0: A wins contention, 1: B wins
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_a_q, grant_b_q, busy_q;

  logic   own_req, own_last, oth_req, beat, burst_end;
  state_e other;

  always_comb begin
    own_req   = (state_q == OWN_A) ? req_a  : req_b;
    own_last  = (state_q == OWN_A) ? last_a : last_b;
    oth_req   = (state_q == OWN_A) ? req_b  : req_a;
    other     = (state_q == OWN_A) ? OWN_B  : OWN_A;
    beat      = (state_q != IDLE) && own_req;
    burst_end = beat && (own_last || (cnt_q == CNT_MAX));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        if (req_a && (!req_b || !prio_q)) state_d = OWN_A;
        else if (req_b)                   state_d = OWN_B;
      end
      OWN_A, OWN_B: begin
        if (burst_end) begin
          cnt_d  = '0;
          prio_d = (state_q == OWN_A);
          // Hand-over beats re-entry; re-entry only when the limit forced the end.
          if (oth_req)        state_d = other;
          else if (!own_last) state_d = state_q;
          else                state_d = IDLE;
        end else if (beat) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      cnt_q     <= '0;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      grant_a_q <= (state_d == OWN_A);
      grant_b_q <= (state_d == OWN_B);
      busy_q    <= (state_d != IDLE);
    end
  end

  assign grant_a  = grant_a_q;
  assign grant_b  = grant_b_q;
  assign sel      = grant_b_q;
  assign busy     = busy_q;
  assign beat_cnt = cnt_q;

`ifdef READ_VEC_ARB_STATS_EN
  logic        new_a, new_b;
  logic [15:0] grants_a_q, grants_b_q;

  // A re-entry after a forced end counts as a fresh grant.
  assign new_a = (state_d == OWN_A) && ((state_q != OWN_A) || burst_end);
  assign new_b = (state_d == OWN_B) && ((state_q != OWN_B) || burst_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      grants_a_q <= '0;
      grants_b_q <= '0;
    end else begin
      if (new_a && (grants_a_q != 16'hFFFF)) grants_a_q <= grants_a_q + 16'd1;
      if (new_b && (grants_b_q != 16'hFFFF)) grants_b_q <= grants_b_q + 16'd1;
    end
  end

  assign grants_a = grants_a_q;
  assign grants_b = grants_b_q;
`endif

endmodule

// File: tb/tb_read_vec_arb.sv
// Directed bench for read_vec_arb: three instances (MAX_BURST 16, 4, 1) share one stimulus.
module tb_read_vec_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_a = 1'b0, last_a = 1'b0, req_b = 1'b0, last_b = 1'b0;

  logic       ga16, gb16, s16, b16;
  logic [4:0] c16;
  logic       ga4, gb4, s4, b4;
  logic [2:0] c4;
  logic       ga1, gb1, s1, b1;
  logic [0:0] c1;
`ifdef READ_VEC_ARB_STATS_EN
  logic [15:0] na16, nb16, na4, nb4, na1, nb1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  read_vec_arb #(.MAX_BURST(16)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .last_a(last_a), .req_b(req_b), .last_b(last_b),
    .grant_a(ga16), .grant_b(gb16), .sel(s16), .busy(b16), .beat_cnt(c16)
`ifdef READ_VEC_ARB_STATS_EN
    , .grants_a(na16), .grants_b(nb16)
`endif
  );

  read_vec_arb #(.MAX_BURST(4)) dut4 (
    .clk(clk), .rst(rst), .req_a(req_a), .last_a(last_a), .req_b(req_b), .last_b(last_b),
    .grant_a(ga4), .grant_b(gb4), .sel(s4), .busy(b4), .beat_cnt(c4)
`ifdef READ_VEC_ARB_STATS_EN
    , .grants_a(na4), .grants_b(nb4)
`endif
  );

  read_vec_arb #(.MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req_a(req_a), .last_a(last_a), .req_b(req_b), .last_b(last_b),
    .grant_a(ga1), .grant_b(gb1), .sel(s1), .busy(b1), .beat_cnt(c1)
`ifdef READ_VEC_ARB_STATS_EN
    , .grants_a(na1), .grants_b(nb1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; last_a = 1'b0; last_b = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_all();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({ga16, gb16, s16, b16, c16} !== 9'd0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got ga=%b gb=%b sel=%b busy=%b cnt=%0d exp all 0",
                 i, ga16, gb16, s16, b16, c16);
      end
    end
  endtask

  task automatic test_single();
    reset_all();
    req_b = 1'b1;
    tick();
    checks++;
    if ({ga16, gb16, s16, b16, c16} !== {4'b0111, 5'd0}) begin
      errors++;
      $display("FAIL single_grant: got ga=%b gb=%b sel=%b busy=%b cnt=%0d exp 0 1 1 1 0",
               ga16, gb16, s16, b16, c16);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if ({gb16, c16} !== {1'b1, 5'(k)}) begin
        errors++;
        $display("FAIL single_cnt: got gb=%b cnt=%0d exp 1 %0d", gb16, c16, k);
      end
    end
    last_b = 1'b1;
    tick();
    checks++;
    if ({b16, c16} !== 6'd0) begin
      errors++;
      $display("FAIL single_end: got busy=%b cnt=%0d exp 0 0", b16, c16);
    end
    req_b = 1'b0; last_b = 1'b0;
  endtask

  task automatic test_contention();
    reset_all();
    req_a = 1'b1; req_b = 1'b1;
    tick();
    for (int g = 0; g < 3; g++) begin
      logic eb;
      eb = logic'(g % 2);
      checks++;
      if ({ga16, gb16, s16, c16} !== {~eb, eb, eb, 5'd0}) begin
        errors++;
        $display("FAIL contend_grant %0d: got ga=%b gb=%b sel=%b cnt=%0d exp %b %b %b 0",
                 g, ga16, gb16, s16, c16, ~eb, eb, eb);
      end
      for (int k = 1; k <= 2; k++) begin
        tick();
        checks++;
        if ({ga16, gb16, c16} !== {~eb, eb, 5'(k)}) begin
          errors++;
          $display("FAIL contend_beat %0d.%0d: got ga=%b gb=%b cnt=%0d exp %b %b %0d",
                   g, k, ga16, gb16, c16, ~eb, eb, k);
        end
      end
      if (eb) last_b = 1'b1; else last_a = 1'b1;
      tick();
      last_a = 1'b0; last_b = 1'b0;
    end
    checks++;
    if ({ga16, gb16, s16} !== 3'b011) begin
      errors++;
      $display("FAIL contend_tail: got ga=%b gb=%b sel=%b exp 0 1 1", ga16, gb16, s16);
    end
    req_a = 1'b0; last_b = 1'b1;
    tick();
    checks++;
    if (b16 !== 1'b0) begin
      errors++;
      $display("FAIL contend_idle: got busy=%b exp 0", b16);
    end
    req_b = 1'b0; last_b = 1'b0;
  endtask

  task automatic test_burst_limit();
    reset_all();
    req_a = 1'b1; req_b = 1'b1;
    tick();
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) tick();
      checks++;
      if ({ga4, gb4, c4} !== {2'b10, 3'(k)}) begin
        errors++;
        $display("FAIL limit_a beat %0d: got ga=%b gb=%b cnt=%0d exp 1 0 %0d", k, ga4, gb4, c4, k);
      end
    end
    tick();
    checks++;
    if ({ga4, gb4, s4, c4} !== {3'b011, 3'd0}) begin
      errors++;
      $display("FAIL limit_handover: got ga=%b gb=%b sel=%b cnt=%0d exp 0 1 1 0", ga4, gb4, s4, c4);
    end
    req_a = 1'b0; last_b = 1'b1;
    tick();
    last_b = 1'b0; req_b = 1'b0; req_a = 1'b1;
    tick();
    for (int k = 1; k <= 3; k++) tick();
    checks++;
    if ({ga4, c4} !== {1'b1, 3'd3}) begin
      errors++;
      $display("FAIL limit_solo: got ga=%b cnt=%0d exp 1 3", ga4, c4);
    end
    tick();
    checks++;
    if ({ga4, gb4, b4, c4} !== {3'b101, 3'd0}) begin
      errors++;
      $display("FAIL limit_reenter: got ga=%b gb=%b busy=%b cnt=%0d exp 1 0 1 0", ga4, gb4, b4, c4);
    end
    last_a = 1'b1;
    tick();
    req_a = 1'b0; last_a = 1'b0;
  endtask

  task automatic test_stall_reset();
    reset_all();
    req_a = 1'b1; tick();
    last_a = 1'b1; tick();
    last_a = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({ga16, c16} !== {1'b1, 5'd2}) begin
      errors++;
      $display("FAIL stall_setup: got ga=%b cnt=%0d exp 1 2", ga16, c16);
    end
    req_a = 1'b0; req_b = 1'b1; last_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({ga16, gb16, c16} !== {2'b10, 5'd2}) begin
        errors++;
        $display("FAIL stall_hold %0d: got ga=%b gb=%b cnt=%0d exp 1 0 2", i, ga16, gb16, c16);
      end
    end
    last_b = 1'b0; req_a = 1'b1; rst = 1'b1;
    tick();
    checks++;
    if ({ga16, gb16, s16, b16, c16} !== 9'd0) begin
      errors++;
      $display("FAIL midburst_reset: got ga=%b gb=%b sel=%b busy=%b cnt=%0d exp all 0",
               ga16, gb16, s16, b16, c16);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({ga16, gb16} !== 2'b10) begin
      errors++;
      $display("FAIL reset_prio: got ga=%b gb=%b exp 1 0", ga16, gb16);
    end
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic test_burst_one();
    reset_all();
    req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic ea;
      ea = (i % 2 == 0);
      tick();
      checks++;
      if ({ga1, gb1, s1, c1} !== {ea, ~ea, ~ea, 1'b0}) begin
        errors++;
        $display("FAIL burst1_alt %0d: got ga=%b gb=%b sel=%b cnt=%0d exp %b %b %b 0",
                 i, ga1, gb1, s1, c1, ea, ~ea, ~ea);
      end
    end
    req_a = 1'b0; req_b = 1'b0;
  endtask

`ifdef READ_VEC_ARB_STATS_EN
  task automatic test_stats();
    reset_all();
    req_a = 1'b1; req_b = 1'b1; last_a = 1'b1; last_b = 1'b1;
    repeat (10) tick();
    checks++;
    if ({na16, nb16} !== {16'd5, 16'd5}) begin
      errors++;
      $display("FAIL stats_count: got a=%0d b=%0d exp 5 5", na16, nb16);
    end
    reset_all();
    req_a = 1'b1;
    repeat (65534) tick();
    checks++;
    if (na1 !== 16'hFFFE) begin
      errors++;
      $display("FAIL stats_presat: got %h exp fffe", na1);
    end
    tick();
    checks++;
    if (na1 !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_sat: got %h exp ffff", na1);
    end
    repeat (3) tick();
    checks++;
    if (na1 !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_nowrap: got %h exp ffff", na1);
    end
    req_a = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_burst_limit();
    test_stall_reset();
    test_burst_one();
`ifdef READ_VEC_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
